// File: rtl/data_mem_resp_pkg.sv
// rtl/data_mem_resp_pkg.sv - shared types and constants for the data memory responder
package data_mem_resp_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Misaligned byte address or word index beyond the array.
    function automatic logic addr_err(input logic [DATA_W-1:0] addr, input int depth);
        return addr[0] || (32'(addr[DATA_W-1:1]) >= 32'(depth));
    endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// rtl/data_mem_resp_if.sv - CPU load/store request and response channel
interface data_mem_resp_if;
    import data_mem_resp_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_mem_resp_dmem_array.sv
// rtl/data_mem_resp_dmem_array.sv - single-port word array, synchronous write, registered read
module dmem_array
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - wait-state memory responder: request capture, FSM, error check
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clock,
    input  logic           reset,
    data_mem_resp_if.slave bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_write;
    logic              r_err;
    logic [AW-1:0]     r_idx;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_in_err;
    logic              w_direct;
    logic              w_acc_write;
    logic              w_acc_err;
    logic [AW-1:0]     w_acc_idx;
    logic [DATA_W-1:0] w_acc_wdata;
    logic              w_enter_resp;
    logic              w_arr_en;
    logic [DATA_W-1:0] w_arr_rdata;

    assign w_accept = bus.req_valid && (r_state == ST_IDLE);
    assign w_in_err = addr_err(bus.req_addr, DEPTH);

    // With no wait states the array is hit on the accept edge, so take operands off the bus.
    assign w_direct    = (r_state == ST_IDLE);
    assign w_acc_write = w_direct ? bus.req_write       : r_write;
    assign w_acc_err   = w_direct ? w_in_err            : r_err;
    assign w_acc_idx   = w_direct ? bus.req_addr[AW:1]  : r_idx;
    assign w_acc_wdata = w_direct ? bus.req_wdata       : r_wdata;

    assign w_enter_resp = !reset &&
                          ((w_accept && (WAIT_CYCLES == 0)) ||
                           ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1))));
    assign w_arr_en     = w_enter_resp && !w_acc_err;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (bus.req_valid)        w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == CNT_W'(1))   w_next = ST_RESP;
            ST_RESP: if (bus.resp_ready)       w_next = ST_IDLE;
            default:                           w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt   <= CNT_W'(WAIT_CYCLES);
                r_write <= bus.req_write;
                r_err   <= w_in_err;
                r_idx   <= bus.req_addr[AW:1];
                r_wdata <= bus.req_wdata;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem_array (
        .i_clk   (clock),
        .i_en    (w_arr_en),
        .i_we    (w_acc_write),
        .i_addr  (w_acc_idx),
        .i_wdata (w_acc_wdata),
        .o_rdata (w_arr_rdata)
    );

    // The array only updates on RESP entry, so the response holds while backpressured.
    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_err   = (r_state == ST_RESP) && r_err;
    assign bus.resp_rdata = ((r_state == ST_RESP) && !r_err && !r_write) ? w_arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_resp.sv
// tb/tb_data_mem_resp.sv - self-checking bench for data_mem_resp (WAIT_CYCLES 0 and 2)
module tb_data_mem_resp;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    data_mem_resp_if bus0 ();
    data_mem_resp_if bus2 ();

    data_mem_resp #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
    data_mem_resp #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut2 (.clock(clock), .reset(reset), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Index 0 is the zero-wait instance, index 1 the two-wait instance.
    logic        m_vld [2];
    logic        m_rq  [2];
    logic        m_rv  [2];
    logic        m_rr  [2];
    logic        m_err [2];
    logic [15:0] m_rd  [2];
    assign m_vld[0] = bus0.req_valid;  assign m_vld[1] = bus2.req_valid;
    assign m_rq[0]  = bus0.req_ready;  assign m_rq[1]  = bus2.req_ready;
    assign m_rv[0]  = bus0.resp_valid; assign m_rv[1]  = bus2.resp_valid;
    assign m_rr[0]  = bus0.resp_ready; assign m_rr[1]  = bus2.resp_ready;
    assign m_err[0] = bus0.resp_err;   assign m_err[1] = bus2.resp_err;
    assign m_rd[0]  = bus0.resp_rdata; assign m_rd[1]  = bus2.resp_rdata;
    logic [15:0] m_addr [2];
    logic [15:0] m_wd   [2];
    logic        m_wr   [2];
    assign m_addr[0] = bus0.req_addr;  assign m_addr[1] = bus2.req_addr;
    assign m_wd[0]   = bus0.req_wdata; assign m_wd[1]   = bus2.req_wdata;
    assign m_wr[0]   = bus0.req_write; assign m_wr[1]   = bus2.req_write;

    // Transaction-level model: one outstanding request per instance, store committed when answered.
    int          waitc [2] = '{0, 2};
    logic [15:0] model_mem [2][256];
    bit          pend  [2] = '{0, 0};
    bit          seen  [2];
    bit          p_wr  [2];
    bit          p_err [2];
    logic [7:0]  p_idx [2];
    logic [15:0] p_wd  [2];
    logic [15:0] p_rd  [2];
    int          acc_cyc [2];
    int          cyc = 0;
    bit          busy;

    always @(negedge clock) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                pend[k] = 1'b0;
            end else begin
                busy = pend[k];
                check("req_ready", m_rq[k], !busy);
                if (m_rv[k]) begin
                    if (!busy) begin
                        check("resp_valid_idle", 1, 0);
                    end else begin
                        if (!seen[k]) begin
                            seen[k] = 1'b1;
                            check("resp_latency", cyc - acc_cyc[k], waitc[k] + 1);
                            if (p_wr[k] && !p_err[k]) model_mem[k][p_idx[k]] = p_wd[k];
                        end
                        check("resp_rdata", m_rd[k], p_rd[k]);
                        check("resp_err", m_err[k], p_err[k]);
                        if (m_rr[k]) pend[k] = 1'b0;
                    end
                end else if (busy && (cyc - acc_cyc[k] == waitc[k] + 1)) begin
                    check("resp_valid_rise", 0, 1);
                end
                if (m_vld[k] && !busy) begin
                    pend[k]    = 1'b1;
                    seen[k]    = 1'b0;
                    acc_cyc[k] = cyc;
                    p_wr[k]    = m_wr[k];
                    p_err[k]   = m_addr[k][0] || (m_addr[k][15:1] >= 15'd256);
                    p_idx[k]   = m_addr[k][8:1];
                    p_wd[k]    = m_wd[k];
                    p_rd[k]    = (m_wr[k] || p_err[k]) ? 16'h0 : model_mem[k][m_addr[k][8:1]];
                end
            end
        end
    end

    task automatic set_req(input int k, input logic v, input logic wr, input logic [15:0] a, input logic [15:0] d);
        if (k == 0) begin
            bus0.req_valid = v; bus0.req_write = wr; bus0.req_addr = a; bus0.req_wdata = d;
        end else begin
            bus2.req_valid = v; bus2.req_write = wr; bus2.req_addr = a; bus2.req_wdata = d;
        end
    endtask

    task automatic set_rr(input int k, input logic r);
        if (k == 0) bus0.resp_ready = r;
        else        bus2.resp_ready = r;
    endtask

    // Returns at the negedge of the accept cycle; n counts negedges waited.
    task automatic wait_accept(input int k, output int n);
        bit ok = 1'b0;
        n = 0;
        while (n < 40) begin
            @(negedge clock);
            n++;
            if (m_vld[k] && m_rq[k] && !reset) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_resp(input int k, output int lat, output logic [15:0] rd, output logic er);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!m_rv[k] && lat < 40);
        if (!m_rv[k]) check("resp_timeout", 0, 1);
        rd = m_rd[k];
        er = m_err[k];
    endtask

    task automatic run_req(input int k, input logic wr, input logic [15:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output logic er, output int lat);
        int n;
        set_rr(k, 1'b1);
        set_req(k, 1'b1, wr, a, d);
        wait_accept(k, n);
        @(posedge clock); #1;
        set_req(k, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_resp(k, lat, rd, er);
        @(posedge clock); #1;
    endtask

    task automatic throughput(input int k, input int cnt, input int period, input logic [15:0] base);
        int n;
        set_rr(k, 1'b1);
        for (int i = 0; i < cnt; i++) begin
            set_req(k, 1'b1, 1'b1, base + 16'(2 * i), 16'h0100 + 16'(i * 16'h0011));
            wait_accept(k, n);
            if (i > 0) check("throughput_period", n, period);
            @(posedge clock); #1;
        end
        set_req(k, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (period + 2) @(posedge clock);
        #1;
    endtask

    logic [15:0] rd;
    logic        er;
    int          lat;
    int          n;

    initial begin
        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
        set_rr(0, 1'b1);
        set_rr(1, 1'b1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", m_rq[1], 1);
        check("rst_resp_valid", m_rv[1], 0);
        check("rst_resp_rdata", m_rd[1], 16'h0);
        check("rst_resp_err", m_err[1], 0);
        check("rst_req_ready0", m_rq[0], 1);
        @(posedge clock); #1;
        reset = 1'b0;

        run_req(1, 1'b1, 16'h0004, 16'h0016, rd, er, lat);
        check("st_lat", lat, 3); check("st_rdata", rd, 16'h0); check("st_err", er, 0);
        run_req(1, 1'b0, 16'h0004, 16'h0, rd, er, lat);
        check("ld_lat", lat, 3); check("ld_rdata", rd, 16'h0016); check("ld_err", er, 0);

        run_req(1, 1'b1, 16'h0002, 16'h5A5A, rd, er, lat);
        run_req(1, 1'b1, 16'h0003, 16'hFFFF, rd, er, lat);
        check("mis_err", er, 1); check("mis_rdata", rd, 16'h0);
        run_req(1, 1'b0, 16'h0002, 16'h0, rd, er, lat);
        check("mis_prior", rd, 16'h5A5A); check("mis_prior_err", er, 0);

        run_req(1, 1'b0, 16'h0200, 16'h0, rd, er, lat);
        check("oor_err", er, 1); check("oor_rdata", rd, 16'h0);

        // Backpressure with a second request held pending behind it.
        set_rr(1, 1'b0);
        set_req(1, 1'b1, 1'b0, 16'h0004, 16'h0);
        wait_accept(1, n);
        @(posedge clock); #1;
        set_req(1, 1'b1, 1'b0, 16'h0002, 16'h0);
        wait_resp(1, lat, rd, er);
        check("bp_lat", lat, 3); check("bp_rdata", rd, 16'h0016);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("bp_valid_hold", m_rv[1], 1);
            check("bp_rdata_hold", m_rd[1], 16'h0016);
            check("bp_req_ready", m_rq[1], 0);
        end
        @(posedge clock); #1;
        set_rr(1, 1'b1);
        @(negedge clock);
        check("hs_valid", m_rv[1], 1);
        check("hs_req_ready", m_rq[1], 0);
        @(posedge clock); #1;
        @(negedge clock);
        check("post_hs_req_ready", m_rq[1], 1);
        @(posedge clock); #1;
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
        wait_resp(1, lat, rd, er);
        check("bp2_lat", lat, 3); check("bp2_rdata", rd, 16'h5A5A);
        @(posedge clock); #1;

        // Reset while a store sits in WAIT must drop it.
        run_req(1, 1'b1, 16'h0008, 16'h1234, rd, er, lat);
        set_req(1, 1'b1, 1'b1, 16'h0008, 16'h00AA);
        wait_accept(1, n);
        @(posedge clock); #1;
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_wait_ready", m_rq[1], 1);
        check("rst_wait_valid", m_rv[1], 0);
        @(posedge clock); #1;
        run_req(1, 1'b0, 16'h0008, 16'h0, rd, er, lat);
        check("rst_store_dropped", rd, 16'h1234);

        throughput(1, 4, 4, 16'h0020);
        run_req(1, 1'b0, 16'h0022, 16'h0, rd, er, lat);
        check("tp2_rdata", rd, 16'h0111);

        throughput(0, 5, 2, 16'h0040);
        run_req(0, 1'b0, 16'h0044, 16'h0, rd, er, lat);
        check("w0_lat", lat, 1); check("w0_rdata", rd, 16'h0122);
        run_req(0, 1'b0, 16'h0201, 16'h0, rd, er, lat);
        check("w0_err", er, 1); check("w0_err_rdata", rd, 16'h0);

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH, default 256, sets the number of 16-bit data words.
REQ-002 Parameter WAIT_CYCLES, default 2, sets the wait states between request accept and response (legal range 0..15).
REQ-003 clock  input  1  Single clock; all state changes on the rising edge.
REQ-004 reset  input  1  Reset is synchronous and active-high.
REQ-005 req_valid  input  1  The CPU presents a load/store request.
REQ-006 req_ready  output  1  The block can accept a request this cycle.
REQ-007 req_write  input  1  1 = store (SW), 0 = load (LW).
REQ-008 req_addr  input  16  Byte address; the word index is req_addr[15:1].
REQ-009 req_wdata  input  16  Store data.
REQ-010 resp_valid  output  1  Response available.
REQ-011 resp_ready  input  1  The CPU accepts the response.
REQ-012 resp_rdata  output  16  Load data; 0 for stores and errors.
REQ-013 resp_err  output  1  The request was misaligned or out of range.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-016 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; req_write, req_addr and req_wdata SHALL be captured on that edge.
REQ-017 After accept, the FSM SHALL enter WAIT when WAIT_CYCLES>0, or RESP directly when WAIT_CYCLES=0.
REQ-018 WAIT SHALL last exactly WAIT_CYCLES cycles, using a 4-bit down-counter loaded on accept.
REQ-019 The array access SHALL occur on the edge that enters RESP, so resp_valid rises WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 A store SHALL update the array on that edge only, and return resp_rdata=0 and resp_err=0.
REQ-021 A load SHALL return the stored word in resp_rdata.
REQ-022 The error condition SHALL be req_addr[0]=1, or word index >= DEPTH.
REQ-023 On error: no array write, resp_err=1, resp_rdata=0.
REQ-024 resp_valid, resp_rdata and resp_err SHALL be held stable in RESP until resp_ready=1.
REQ-025 The edge where resp_valid=1 and resp_ready=1 SHALL return the FSM to IDLE.
REQ-026 No new request SHALL be accepted in the same cycle as the response handshake; the earliest next accept is the cycle after.
REQ-027 req_valid while not in IDLE SHALL be ignored; the requester holds it, and the request is accepted once IDLE is reached.
REQ-028 Back-to-back throughput SHALL be one request per WAIT_CYCLES+2 cycles when resp_ready is tied to 1.
REQ-029 A store followed by a load to the same address SHALL return the stored value (no read-before-write hazard across requests).

Reset
REQ-030 reset=1 SHALL force state IDLE, wait counter 0, req_ready=1 in the following cycle, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-031 Reset during WAIT SHALL abort the request; a pending store SHALL NOT be committed.
REQ-032 Reset during RESP SHALL drop the response with no handshake required.
REQ-033 Array contents SHALL be unaffected by reset.
REQ-034 reset SHALL take priority over any simultaneous req_valid or resp_ready.

Structure
REQ-035 The shared package SHALL hold the state encoding (IDLE=0, WAIT=1, RESP=2), the 16-bit data/address width constant and the counter width constant.
REQ-036 Storage SHALL be a single sub-module, dmem_array: a DEPTH x 16 single-port array with synchronous write and registered read, enabled only on the RESP-entry edge.
REQ-037 The FSM, counter, request capture and error check SHALL live in data_mem_resp.

Verification
REQ-038 Store then load: store addr 0x0004 data 0x0016, then load addr 0x0004 -> resp_rdata=0x0016, resp_err=0; each resp_valid rises 3 cycles after its accept (WAIT_CYCLES=2).
REQ-039 Misaligned store: addr 0x0003 data 0xFFFF -> resp_err=1, rdata=0; a later load from 0x0002 returns its prior value unchanged.
REQ-040 Out-of-range load: addr 0x0200 (word 256, DEPTH=256) -> resp_err=1, rdata=0.
REQ-041 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and data stable throughout, req_ready=0, and a second req_valid is not accepted until 1 cycle after the handshake.
REQ-042 Reset mid-store: accept store addr 0x0008 data 0x00AA, assert reset in WAIT -> FSM in IDLE, and a load of 0x0008 returns the old value.
REQ-043 WAIT_CYCLES=0 with resp_ready tied to 1 -> resp_valid in the cycle after accept, and sustained throughput is one request per 2 cycles.
